// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared pipeline constants. Holds the stall-vector bit
//                positions, the stage action encoding and the action decode
//                used by the stage registers.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    // Bit positions inside the stage stall vector
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    // Stage register action encoding
    localparam logic [1:0] ACT_LOAD   = 2'd0;
    localparam logic [1:0] ACT_HOLD   = 2'd1;
    localparam logic [1:0] ACT_BUBBLE = 2'd2;

    // Resolve the action for one edge. Flush wins over everything, then a
    // downstream stall freezes the stage, then an upstream-only stall forces
    // a bubble so the stalled instruction cannot commit twice.
    function automatic logic [1:0] decode_action(input logic flush,
                                                 input logic stall_up,
                                                 input logic stall_here);
        logic [1:0] act;
        act = ACT_LOAD;
        if (flush)           act = ACT_BUBBLE;
        else if (stall_here) act = ACT_HOLD;
        else if (stall_up)   act = ACT_BUBBLE;
        return act;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_field_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_field_reg
//  Description : Width-parametrised enabled register with synchronous
//                active-low clear, used for pipeline data/address fields.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_field_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Capture d when enabled; otherwise the field holds its value
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/mem_wb_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_pipe
//  Description : MEM->WB pipeline register carrying the GPR, HI/LO, LLbit and
//                CP0 write channels, with flush, bubble insertion, a valid
//                bit and a retired-instruction counter.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_wb_pipe
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int CP0_AW  = 5,
    parameter int STALL_W = 6,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [STALL_W-1:0] stall,
    input  logic              flush,
    input  logic              cnt_clr,
    input  logic              mem_valid,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_whilo,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    input  logic              mem_LLbit_we,
    input  logic              mem_LLbit_value,
    input  logic              mem_cp0_reg_we,
    input  logic [CP0_AW-1:0] mem_cp0_reg_write_addr,
    input  logic [DATA_W-1:0] mem_cp0_reg_data,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_waddr,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_whilo,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
    output logic              wb_LLbit_we,
    output logic              wb_LLbit_value,
    output logic              wb_cp0_reg_we,
    output logic [CP0_AW-1:0] wb_cp0_reg_write_addr,
    output logic [DATA_W-1:0] wb_cp0_reg_data,
    output logic [CNT_W-1:0]  wb_retire_cnt
);

    logic [1:0]       w_act;
    logic             w_load;
    logic             r_valid;
    logic             r_we;
    logic             r_whilo;
    logic             r_llbit_we;
    logic             r_cp0_we;
    logic [CNT_W-1:0] r_cnt;

    // Pick this edge's single action from flush and the two stall bits
    always_comb begin
        w_act  = decode_action(flush, stall[STALL_MEM], stall[STALL_WB]);
        w_load = (w_act == ACT_LOAD);
    end

    // Data/address fields only change on a load; bubbles leave them intact
    pipe_field_reg #(.W(REG_AW)) u_waddr (
        .clk(clk), .reset_n(reset_n), .en(w_load), .d(mem_waddr), .q(wb_waddr)
    );
    pipe_field_reg #(.W(DATA_W)) u_wdata (
        .clk(clk), .reset_n(reset_n), .en(w_load), .d(mem_wdata), .q(wb_wdata)
    );
    pipe_field_reg #(.W(DATA_W)) u_hi (
        .clk(clk), .reset_n(reset_n), .en(w_load), .d(mem_hi), .q(wb_hi)
    );
    pipe_field_reg #(.W(DATA_W)) u_lo (
        .clk(clk), .reset_n(reset_n), .en(w_load), .d(mem_lo), .q(wb_lo)
    );
    pipe_field_reg #(.W(1)) u_llbit_value (
        .clk(clk), .reset_n(reset_n), .en(w_load),
        .d(mem_LLbit_value), .q(wb_LLbit_value)
    );
    pipe_field_reg #(.W(CP0_AW)) u_cp0_addr (
        .clk(clk), .reset_n(reset_n), .en(w_load),
        .d(mem_cp0_reg_write_addr), .q(wb_cp0_reg_write_addr)
    );
    pipe_field_reg #(.W(DATA_W)) u_cp0_data (
        .clk(clk), .reset_n(reset_n), .en(w_load),
        .d(mem_cp0_reg_data), .q(wb_cp0_reg_data)
    );

    // Valid and write enables: cleared on bubble, gated by mem_valid on load
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid    <= 1'b0;
            r_we       <= 1'b0;
            r_whilo    <= 1'b0;
            r_llbit_we <= 1'b0;
            r_cp0_we   <= 1'b0;
        end else if (w_act == ACT_BUBBLE) begin
            r_valid    <= 1'b0;
            r_we       <= 1'b0;
            r_whilo    <= 1'b0;
            r_llbit_we <= 1'b0;
            r_cp0_we   <= 1'b0;
        end else if (w_load) begin
            r_valid    <= mem_valid;
            r_we       <= mem_we         & mem_valid;
            r_whilo    <= mem_whilo      & mem_valid;
            r_llbit_we <= mem_LLbit_we   & mem_valid;
            r_cp0_we   <= mem_cp0_reg_we & mem_valid;
        end
    end

    // Retire counter: clear beats increment, counts valid loads, wraps freely
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_load && mem_valid) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign wb_valid      = r_valid;
    assign wb_we         = r_we;
    assign wb_whilo      = r_whilo;
    assign wb_LLbit_we   = r_llbit_we;
    assign wb_cp0_reg_we = r_cp0_we;
    assign wb_retire_cnt = r_cnt;

endmodule
`default_nettype wire
